can_destuff_crc: RTL

Receive-path stage directly upstream of candecoder. It takes the raw sampled bus bit and the sample-point strobe from the bit-timing logic, and removes stuff bits while checking for stuff errors. It delivers a destuffed bit stream plus a valid strobe, and keeps a running CRC-15 that the decoder latches at the end of the data field. It also detects bus-idle (11 recessive bits) for frame/error recovery.

---
 rtl/can_pkg.sv | 15 +
 rtl/can_crc15.sv | 18 +
 rtl/can_destuff_crc.sv | 136 +++++++++++++
 3 files changed

// File: rtl/can_pkg.sv
// Shared CAN receive/transmit constants, the destuffer state encoding and CRC-15 width.
package can_pkg;

  localparam int          CRC_W     = 15;
  localparam logic [14:0] CRC_POLY  = 15'h4599;
  localparam int          STUFF_LEN = 5;
  localparam int          IDLE_BITS = 11;

  typedef enum logic [1:0] {
    IDLE,
    FRAME,
    ERR
  } state_t;

endpackage

// File: rtl/can_crc15.sv
// Combinational one-bit step of the CAN CRC-15; shared by the receive and transmit paths.
module can_crc15
  import can_pkg::*;
#(
  parameter logic [CRC_W-1:0] POLY = CRC_POLY
) (
  input  logic [CRC_W-1:0] crc_in,
  input  logic             data_bit,
  input  logic             enable,
  output logic [CRC_W-1:0] crc_out
);

  logic feedback;

  assign feedback = data_bit ^ crc_in[CRC_W-1];
  assign crc_out  = enable ? ({crc_in[CRC_W-2:0], 1'b0} ^ (feedback ? POLY : '0)) : crc_in;

endmodule

// File: rtl/can_destuff_crc.sv
// CAN receive bit destuffer: removes stuff bits, flags stuff errors, runs CRC-15 and detects bus idle.
module can_destuff_crc #(
  parameter int          IDLE_BITS = can_pkg::IDLE_BITS,
  parameter int          STUFF_LEN = can_pkg::STUFF_LEN,
  parameter logic [14:0] CRC_POLY  = can_pkg::CRC_POLY
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sample_tick,
  input  logic        rx_bit,
  input  logic        stuff_en,
  input  logic        crc_hold,
  input  logic        frame_done,
  output logic        bit_valid,
  output logic        bit_out,
  output logic [14:0] crc,
  output logic        stuff_error,
  output logic        in_frame,
  output logic        bus_idle
);

  import can_pkg::*;

  localparam int            RW        = $clog2(STUFF_LEN + 1);
  localparam int            IW        = $clog2(IDLE_BITS + 1);
  localparam logic [RW-1:0] STUFF_MAX = RW'(STUFF_LEN);
  localparam logic [IW-1:0] IDLE_MAX  = IW'(IDLE_BITS);

  state_t        state_q, state_d;
  logic [RW-1:0] run_cnt_q, run_cnt_d;
  logic          run_val_q, run_val_d;
  logic [IW-1:0] idle_cnt_q, idle_cnt_d;
  logic          emit, stuff_err_d, crc_en, crc_clr;
  logic [14:0]   crc_next;

  can_crc15 #(.POLY(CRC_POLY)) u_crc (
    .crc_in   (crc),
    .data_bit (rx_bit),
    .enable   (crc_en),
    .crc_out  (crc_next)
  );

  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    run_cnt_d   = run_cnt_q;
    run_val_d   = run_val_q;
    idle_cnt_d  = idle_cnt_q;
    emit        = 1'b0;
    stuff_err_d = 1'b0;
    crc_en      = 1'b0;
    crc_clr     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (sample_tick && !rx_bit) begin
          emit      = 1'b1;
          crc_clr   = 1'b1;
          run_val_d = 1'b0;
          run_cnt_d = RW'(1);
          state_d   = FRAME;
        end
      end

      FRAME: begin
        if (sample_tick) begin
          if (stuff_en && run_cnt_q == STUFF_MAX) begin
            if (rx_bit != run_val_q) begin
              run_val_d = rx_bit;
              run_cnt_d = RW'(1);
            end else begin
              stuff_err_d = 1'b1;
              state_d     = ERR;
            end
          end else begin
            emit   = 1'b1;
            crc_en = !crc_hold;
            if (rx_bit == run_val_q) begin
              if (run_cnt_q != STUFF_MAX) run_cnt_d = run_cnt_q + 1'b1;
            end else begin
              run_val_d = rx_bit;
              run_cnt_d = RW'(1);
            end
          end
        end
        // The decoder's end-of-frame wins over any error raised by the same bit.
        if (frame_done) state_d = IDLE;
      end

      ERR: begin
        if (sample_tick) begin
          emit       = 1'b1;
          idle_cnt_d = rx_bit ? idle_cnt_q + 1'b1 : '0;
          if (idle_cnt_d == IDLE_MAX) begin
            state_d    = IDLE;
            idle_cnt_d = '0;
          end
        end
        if (frame_done) begin
          state_d    = IDLE;
          idle_cnt_d = '0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: reset is synchronous, so rst_n is only tested inside the clocked block.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bit_valid   <= 1'b0;
      bit_out     <= 1'b1;
      crc         <= '0;
      stuff_error <= 1'b0;
      in_frame    <= 1'b0;
      bus_idle    <= 1'b1;
      run_cnt_q   <= '0;
      run_val_q   <= 1'b1;
      idle_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      bit_valid   <= emit;
      if (emit) bit_out <= rx_bit;
      crc         <= crc_clr ? '0 : crc_next;
      stuff_error <= stuff_err_d;
      in_frame    <= (state_d == FRAME);
      bus_idle    <= (state_d == IDLE);
      run_cnt_q   <= run_cnt_d;
      run_val_q   <= run_val_d;
      idle_cnt_q  <= idle_cnt_d;
    end
  end

endmodule
